// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared widths and dump FSM encoding for the register-file debug reader
package reg_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HALT = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

  // Every non-idle state owns the shared read port and keeps the CPU frozen.
  function automatic logic state_active(input dump_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - halts the CPU, walks the register file and streams each word out
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cpu_halt,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       r_state;
  dump_state_t       w_next_state;
  logic [ADDR_W-1:0] r_index;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_index;
  logic              r_out_valid;
  logic              w_handshake;
  logic              w_last;

  assign w_handshake = r_out_valid && out_ready;
  assign w_last      = (r_index == LAST_IDX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_HALT;
      ST_HALT: w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_SEND;
      ST_SEND: if (w_handshake) w_next_state = w_last ? ST_DONE : ST_LOAD;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = state_active(r_state);
    cpu_halt = state_active(r_state);
    done     = (r_state == ST_DONE);
  end

  // Captured word stays frozen across any amount of backpressure in SEND.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_index     <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_index <= '0;
        end
        ST_LOAD: begin
          r_out_data  <= rd_data;
          r_out_index <= r_index;
          r_out_valid <= 1'b1;
        end
        ST_SEND: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (!w_last) r_index <= r_index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr   = r_index;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized bench for reg_dump_reader against a snapshot model
module tb_reg_dump_reader;
  import reg_dump_reader_pkg::*;

  localparam int AW = REG_ADDR_W;
  localparam int DW = REG_DATA_W;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          start;
  logic          out_ready;
  logic          sel;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] regs [0:31];

  logic [AW-1:0] rd_addr_a, rd_addr_b, out_index_a, out_index_b;
  logic [DW-1:0] rd_data_a, rd_data_b, out_data_a, out_data_b;
  logic cpu_halt_a, cpu_halt_b, busy_a, busy_b, out_valid_a, out_valid_b, done_a, done_b;

  logic [AW-1:0] m_rd_addr, m_out_index;
  logic [DW-1:0] m_out_data;
  logic m_cpu_halt, m_busy, m_out_valid, m_done;

  int n_checks = 0;
  int n_fail   = 0;
  int max_b    = 0;

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  assign m_rd_addr   = sel ? rd_addr_b   : rd_addr_a;
  assign m_out_index = sel ? out_index_b : out_index_a;
  assign m_out_data  = sel ? out_data_b  : out_data_a;
  assign m_cpu_halt  = sel ? cpu_halt_b  : cpu_halt_a;
  assign m_busy      = sel ? busy_b      : busy_a;
  assign m_out_valid = sel ? out_valid_b : out_valid_a;
  assign m_done      = sel ? done_b      : done_a;

  // Register file write port, gated by cpu_halt the way the CPU top level does.
  always @(posedge clock) begin
    if (we && !m_cpu_halt) regs[waddr] <= wdata;
  end

  always @(posedge clock) begin
    if (int'(rd_addr_b) > max_b) max_b <= int'(rd_addr_b);
  end

  reg_dump_reader #(.NUM_REGS(32)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .start(start && !sel),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .cpu_halt(cpu_halt_a), .busy(busy_a),
    .out_valid(out_valid_a), .out_ready(out_ready && !sel), .out_data(out_data_a),
    .out_index(out_index_a), .done(done_a)
  );

  reg_dump_reader #(.NUM_REGS(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .start(start && sel),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .cpu_halt(cpu_halt_b), .busy(busy_b),
    .out_valid(out_valid_b), .out_ready(out_ready && sel), .out_data(out_data_b),
    .out_index(out_index_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, m_out_valid, 0);
    check({tag, "_data"},  m_out_data, 0);
    check({tag, "_index"}, m_out_index, 0);
    check({tag, "_rdaddr"}, m_rd_addr, 0);
    check({tag, "_halt"},  m_cpu_halt, 0);
    check({tag, "_busy"},  m_busy, 0);
    check({tag, "_done"},  m_done, 0);
  endtask

  // Entered and left at a falling edge while the selected reader is idle.
  task automatic preload(input bit rnd);
    for (int i = 0; i < 32; i++) begin
      we    = 1'b1;
      waddr = AW'(i);
      wdata = rnd ? DW'($urandom) : 32'hA5A50000 + DW'(i);
      @(posedge clock);
      @(negedge clock);
    end
    we = 1'b0;
  endtask

  task automatic run_dump(input int nregs, input int stall_word, input int stall_len,
                          input bit rnd_ready, input int pulse_word, input bit hold_start,
                          input int abort_word);
    logic [DW-1:0] snap [0:31];
    int cyc, got, n_stall, first_valid, halt_cyc, stall_cnt;
    start = 1'b1;
    we    = 1'b0;
    @(posedge clock);
    cyc = 0; got = 0; n_stall = 0; first_valid = -1; halt_cyc = 0; stall_cnt = 0;
    @(negedge clock);
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    while (got < nregs && cyc < 4000) begin
      check("halt_in_dump", m_cpu_halt, 1);
      check("busy_in_dump", m_busy, 1);
      halt_cyc++;
      start = hold_start || (got == pulse_word);
      if (m_out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        check("out_index", m_out_index, got);
        check("out_data", m_out_data, snap[got]);
        if (got == abort_word) begin
          #2 reset_n = 1'b0;
          #1 check_all_zero("async_reset");
          start = 1'b0; we = 1'b0; out_ready = 1'b0;
          @(posedge clock);
          @(posedge clock);
          @(negedge clock);
          reset_n = 1'b1;
          return;
        end
        if (got == stall_word && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else if (rnd_ready) begin
          out_ready = ($urandom_range(0, 2) != 0);
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) got++;
        else n_stall++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      we    = 1'b1;
      waddr = (cyc == 3) ? AW'(7) : AW'($urandom_range(0, 31));
      wdata = (cyc == 3) ? 32'hDEADBEEF : DW'($urandom);
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    we    = 1'b0;
    start = hold_start;
    check("words_seen", got, nregs);
    check("first_valid_cycle", first_valid, 2);
    if (stall_word >= 0) check("stall_cycles", stall_cnt, stall_len);
    check("done_pulse", m_done, 1);
    check("done_halt", m_cpu_halt, 1);
    check("done_valid", m_out_valid, 0);
    halt_cyc++;
    check("halt_cycles", halt_cyc, 2 + 2 * nregs + n_stall);
    @(posedge clock);
    @(negedge clock);
    check("idle_done", m_done, 0);
    check("idle_halt", m_cpu_halt, 0);
    check("idle_busy", m_busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset32");
    sel = 1'b1;
    #1 check_all_zero("reset4");
    sel = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    preload(1'b0);
    run_dump(32, -1, 0, 1'b0, -1, 1'b0, -1);
    run_dump(32, 5, 10, 1'b0, 12, 1'b1, -1);
    run_dump(32, -1, 0, 1'b1, -1, 1'b0, 20);
    @(negedge clock);
    check("post_reset_idle", m_busy, 0);
    preload(1'b1);
    run_dump(32, 3, 4, 1'b1, -1, 1'b0, -1);
    run_dump(32, -1, 0, 1'b1, 30, 1'b0, -1);

    sel = 1'b1;
    @(negedge clock);
    preload(1'b1);
    run_dump(4, -1, 0, 1'b0, -1, 1'b0, -1);
    run_dump(4, 1, 3, 1'b1, 2, 1'b1, -1);
    run_dump(4, -1, 0, 1'b1, -1, 1'b0, -1);
    check("idx4_max", max_b, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
